// File: rtl/time_set_ctrl.sv
// Hour/minute/second timekeeper with a RUN mode and three field-setting modes driven by
// mode/inc buttons. Optional idle auto-return to RUN is enabled by defining SET_TIMEOUT_EN.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick1hz,
  input  logic       blink,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blank_h,
  output logic       blank_m,
  output logic       blank_s
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       mode_q, inc_q;
  logic       mode_press, inc_press, timeout_hit;
  logic [4:0] hour_d;
  logic [5:0] min_d, sec_d;

  // A mode press shadows an inc press in the same cycle.
  assign mode_press = btn_mode & ~mode_q;
  assign inc_press  = btn_inc & ~inc_q & ~mode_press;

`ifdef SET_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_S);
  logic [7:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state_q == RUN || mode_press || inc_press || timeout_hit) begin
      idle_cnt <= '0;
    end else if (tick1hz) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign timeout_hit = (state_q != RUN) & tick1hz & ~mode_press & ~inc_press &
                       (idle_cnt == TIMEOUT_CNT - 8'd1);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^8'(TIMEOUT_S);
  assign timeout_hit      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end else if (timeout_hit) begin
      state_d = RUN;
    end
  end

  // RUN advances on the tick even when a mode press leaves RUN in the same cycle.
  always_comb begin
    hour_d = hour;
    min_d  = min;
    sec_d  = sec;
    case (state_q)
      RUN: begin
        if (tick1hz) begin
          if (sec == 6'd59) begin
            sec_d = '0;
            if (min == 6'd59) begin
              min_d  = '0;
              hour_d = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end else begin
              min_d = min + 6'd1;
            end
          end else begin
            sec_d = sec + 6'd1;
          end
        end
      end
      SET_H: if (inc_press) hour_d = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      SET_M: if (inc_press) min_d = (min == 6'd59) ? 6'd0 : min + 6'd1;
      SET_S: if (inc_press) sec_d = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= 1'b1;
      inc_q   <= 1'b1;
      hour    <= '0;
      min     <= '0;
      sec     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      hour    <= hour_d;
      min     <= min_d;
      sec     <= sec_d;
    end
  end

  assign mode    = state_q;
  assign blank_h = (state_q == SET_H) & blink;
  assign blank_m = (state_q == SET_M) & blink;
  assign blank_s = (state_q == SET_S) & blink;

endmodule
